// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU: opcode values, FSM state encoding and
// helpers that derive field widths and per-opcode side effects.
package cpu_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_OUT = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hD;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  // Register-address width for a register file of nreg entries.
  function automatic int ra_width(input int nreg);
    return $clog2(nreg);
  endfunction

  // Full instruction word width: opcode, rd, rs, immediate.
  function automatic int instr_width(input int nreg, input int pc_w);
    return OPCODE_W + 2 * ra_width(nreg) + pc_w;
  endfunction

  // ALU ops plus MOV/LDI write the destination register.
  function automatic logic writes_rd(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  // Only arithmetic/logic/shift ops touch the zero flag; MOV/LDI do not.
  function automatic logic sets_z(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return op > OP_HLT;
  endfunction

endpackage

// File: rtl/mini_cpu_core_if.sv
// Bundle of the CPU's instruction-fetch and output-port signals, used by the
// environment to hook a ROM and an output monitor to the core.
//
// Handshake: out_valid is a valid-only strobe with no ready. It is high for
// exactly one cycle per OUT instruction; cpu_out carries the new value in that
// cycle and holds it until the next OUT. imem_data answers imem_addr one
// cycle later (synchronous ROM), with no stall signalling.
interface mini_cpu_core_if #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 18
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [DATA_W-1:0]  cpu_out;
  logic               out_valid;
  logic               halted;
  logic               illegal;

  modport master (
    output imem_addr, cpu_out, out_valid, halted, illegal,
    input  imem_data
  );

  modport slave (
    input  imem_addr, cpu_out, out_valid, halted, illegal,
    output imem_data
  );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU covering the register-writing opcodes. MOV and LDI pass
// operand b through; the core feeds the immediate on b for LDI.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Select the operation result; unsupported opcodes yield zero.
  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = b;
      OP_LDI:  result = b;
      OP_SHL:  result = a << 1;
      OP_SHR:  result = a >> 1;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/mini_cpu_core.sv
// Multi-cycle mini CPU: FETCH/DECODE/EXECUTE/WRITEBACK per instruction, with a
// terminal HALT state. All architectural writes happen on the WRITEBACK edge,
// so a reset before then leaves no trace of the abandoned instruction.
module mini_cpu_core
  import cpu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREG    = 8,
  parameter  int PC_W    = 8,
  localparam int RA_W    = ra_width(NREG),
  localparam int INSTR_W = instr_width(NREG, PC_W)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [DATA_W-1:0]  cpu_out,
  output logic               out_valid,
  output logic               halted,
  output logic               illegal,
  output state_e             dbg_state_o,
  output logic               dbg_zflag_o
);

  localparam int RD_LSB = INSTR_W - OPCODE_W - RA_W;
  localparam int RS_LSB = PC_W;

  state_e state_q, state_d;

  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_nxt_q;
  logic [3:0]        op_q;
  logic [RA_W-1:0]   rd_q;
  logic [PC_W-1:0]   imm_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] res_q;
  logic              res_zero_q;
  logic              z_q;
  logic [DATA_W-1:0] cpu_out_q;
  logic              out_valid_q;
  logic              illegal_q;
  logic [DATA_W-1:0] regs_q [NREG];

  logic [3:0]        dec_op;
  logic [RA_W-1:0]   dec_rd, dec_rs;
  logic [PC_W-1:0]   dec_imm;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_target;

  assign dec_op  = imem_data[INSTR_W-1 -: OPCODE_W];
  assign dec_rd  = imem_data[RD_LSB +: RA_W];
  assign dec_rs  = imem_data[RS_LSB +: RA_W];
  assign dec_imm = imem_data[PC_W-1:0];

  // Immediate is zero-extended or truncated to the data width for LDI.
  assign imm_ext = DATA_W'(imm_q);
  assign alu_b   = (op_q == OP_LDI) ? imm_ext : b_q;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (op_q),
    .a      (a_q),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Next PC: jumps take the immediate, HLT keeps PC, everything else wraps +1.
  always_comb begin
    pc_inc    = pc_q + PC_W'(1);
    pc_target = pc_inc;
    case (op_q)
      OP_JMP:  pc_target = imm_q;
      OP_JZ:   if (z_q) pc_target = imm_q;
      OP_HLT:  pc_target = pc_q;
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // FSM next-state: fixed four-step sequence, HLT parks in HALT until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = (op_q == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Datapath: latch the instruction and operands, compute, then commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= '0;
      pc_nxt_q    <= '0;
      op_q        <= OP_NOP;
      rd_q        <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      res_zero_q  <= 1'b0;
      z_q         <= 1'b0;
      cpu_out_q   <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_DECODE: begin
          // Both operands are read before any write, so rd==rs sees the old value twice.
          op_q  <= dec_op;
          rd_q  <= dec_rd;
          imm_q <= dec_imm;
          a_q   <= regs_q[dec_rd];
          b_q   <= regs_q[dec_rs];
        end
        ST_EXECUTE: begin
          res_q      <= alu_result;
          res_zero_q <= alu_zero;
          pc_nxt_q   <= pc_target;
          // Output register and strobe become visible during WRITEBACK.
          if (op_q == OP_OUT) begin
            cpu_out_q   <= a_q;
            out_valid_q <= 1'b1;
          end
        end
        ST_WRITEBACK: begin
          if (writes_rd(op_q))   regs_q[rd_q] <= res_q;
          if (sets_z(op_q))      z_q          <= res_zero_q;
          if (is_reserved(op_q)) illegal_q    <= 1'b1;
          pc_q <= pc_nxt_q;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign cpu_out     = cpu_out_q;
  assign out_valid   = out_valid_q;
  assign halted      = (state_q == ST_HALT);
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;
  assign dbg_zflag_o = z_q;

endmodule

// File: tb/tb_mini_cpu_core.sv
// Bench for mini_cpu_core: an instruction-level ISA model predicts fetch
// addresses, OUT pulses, flags and halting for the default-sized core; a
// second 16-bit / 16-register core is used for the reset-during-EXECUTE case.
module tb_mini_cpu_core;
  import cpu_pkg::*;

  localparam int IW  = 18;
  localparam int IW2 = 20;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset2 = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- default DUT ----------------
  mini_cpu_core_if #(.DATA_W(8), .PC_W(8), .INSTR_W(IW)) bus ();
  state_e dbg_state;
  logic   dbg_z;
  logic [IW-1:0] rom [256];

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  mini_cpu_core #(.DATA_W(8), .NREG(8), .PC_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (bus.imem_addr),
    .imem_data   (bus.imem_data),
    .cpu_out     (bus.cpu_out),
    .out_valid   (bus.out_valid),
    .halted      (bus.halted),
    .illegal     (bus.illegal),
    .dbg_state_o (dbg_state),
    .dbg_zflag_o (dbg_z)
  );

  // ---------------- wide DUT ----------------
  logic [7:0]     imem_addr2;
  logic [IW2-1:0] imem_data2;
  logic [15:0]    cpu_out2;
  logic           out_valid2, halted2, illegal2, dbg_z2;
  state_e         dbg_state2;
  logic [IW2-1:0] rom2 [256];

  always @(posedge clk) imem_data2 <= rom2[imem_addr2];

  mini_cpu_core #(.DATA_W(16), .NREG(16), .PC_W(8)) dut2 (
    .clk         (clk),
    .reset       (reset2),
    .imem_addr   (imem_addr2),
    .imem_data   (imem_data2),
    .cpu_out     (cpu_out2),
    .out_valid   (out_valid2),
    .halted      (halted2),
    .illegal     (illegal2),
    .dbg_state_o (dbg_state2),
    .dbg_zflag_o (dbg_z2)
  );

  // ---------------- instruction encoders ----------------
  function automatic logic [IW-1:0] ins(input logic [3:0] op, input int rd, input int rs, input int imm);
    return {op, 3'(rd), 3'(rs), 8'(imm)};
  endfunction

  function automatic logic [IW2-1:0] ins2(input logic [3:0] op, input int rd, input int rs, input int imm);
    return {op, 4'(rd), 4'(rs), 8'(imm)};
  endfunction

  // ---------------- ISA reference model ----------------
  logic [7:0] m_r [8];
  logic [7:0] m_pc, m_out;
  logic       m_z, m_ill, m_halt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_pc = 8'h00; m_out = 8'h00; m_z = 1'b0; m_ill = 1'b0; m_halt = 1'b0;
  endtask

  // Executes one whole instruction; reports whether it produced an OUT.
  task automatic model_step(output bit evt, output logic [7:0] val);
    logic [IW-1:0] w;
    logic [3:0] op;
    logic [2:0] rd, rs;
    logic [7:0] imm, x, y, r, nxt;
    bit wr, zu;
    w = rom[m_pc];
    op = w[17:14]; rd = w[13:11]; rs = w[10:8]; imm = w[7:0];
    x = m_r[rd]; y = m_r[rs];
    r = 8'h00; wr = 0; zu = 0; evt = 0; val = 8'h00;
    nxt = m_pc + 8'd1;
    case (op)
      4'h1: begin r = x + y;     wr = 1; zu = 1; end
      4'h2: begin r = x - y;     wr = 1; zu = 1; end
      4'h3: begin r = x & y;     wr = 1; zu = 1; end
      4'h4: begin r = x | y;     wr = 1; zu = 1; end
      4'h5: begin r = x ^ y;     wr = 1; zu = 1; end
      4'h6: begin r = y;         wr = 1; end
      4'h7: begin r = imm;       wr = 1; end
      4'h8: begin r = x * 8'd2;  wr = 1; zu = 1; end
      4'h9: begin r = x / 8'd2;  wr = 1; zu = 1; end
      4'hA: nxt = imm;
      4'hB: if (m_z) nxt = imm;
      4'hC: begin evt = 1; val = x; m_out = x; end
      4'hD: begin m_halt = 1; nxt = m_pc; end
      4'hE, 4'hF: m_ill = 1;
      default: ;
    endcase
    if (wr) m_r[rd] = r;
    if (zu) m_z = (r == 8'h00);
    m_pc = nxt;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_reset();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at the first cycle of an instruction slot; walks n slots of 4 cycles
  // and compares every cycle against the ISA model.
  task automatic run_instrs(input int n, input string tag);
    bit evt;
    logic [7:0] val;
    logic want_ov;
    for (int k = 0; k < n; k++) begin
      if (m_halt) begin
        for (int c = 0; c < 4; c++) begin
          checks++;
          if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_addr !== m_pc) begin
            errors++;
            $display("FAIL %s halt_hold: halted=%b out_valid=%b addr=%h, want 1 0 %h",
                     tag, bus.halted, bus.out_valid, bus.imem_addr, m_pc);
          end
          @(negedge clk);
        end
      end else begin
        checks++;
        if (bus.imem_addr !== m_pc || bus.halted !== 1'b0 || bus.illegal !== m_ill ||
            bus.cpu_out !== m_out || bus.out_valid !== 1'b0 || dbg_z !== m_z) begin
          errors++;
          $display("FAIL %s fetch slot%0d: addr=%h halted=%b illegal=%b out=%h ov=%b z=%b, want %h 0 %b %h 0 %b",
                   tag, k, bus.imem_addr, bus.halted, bus.illegal, bus.cpu_out, bus.out_valid, dbg_z,
                   m_pc, m_ill, m_out, m_z);
        end
        model_step(evt, val);
        for (int c = 1; c < 4; c++) begin
          @(negedge clk);
          want_ov = (c == 3) ? evt : 1'b0;
          checks++;
          if (bus.out_valid !== want_ov || (want_ov && bus.cpu_out !== val)) begin
            errors++;
            $display("FAIL %s out slot%0d cyc%0d: out_valid=%b cpu_out=%h, want %b %h",
                     tag, k, c + 1, bus.out_valid, bus.cpu_out, want_ov, val);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.imem_addr !== 8'h00 || bus.cpu_out !== 8'h00 || bus.out_valid !== 1'b0 ||
        bus.halted !== 1'b0 || bus.illegal !== 1'b0 || dbg_state !== ST_FETCH || dbg_z !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: addr=%h out=%h ov=%b halted=%b illegal=%b state=%0d z=%b, want all zero",
               bus.imem_addr, bus.cpu_out, bus.out_valid, bus.halted, bus.illegal, dbg_state, dbg_z);
    end
  endtask

  task automatic test_add_out();
    hold_reset();
    clear_rom();
    rom[0] = ins(OP_LDI, 1, 0, 5);
    rom[1] = ins(OP_LDI, 2, 0, 3);
    rom[2] = ins(OP_ADD, 1, 2, 0);
    rom[3] = ins(OP_OUT, 1, 0, 0);
    rom[4] = ins(OP_HLT, 0, 0, 0);
    release_reset();
    run_instrs(4, "add_out");
    checks++;
    if (bus.cpu_out !== 8'd8) begin
      errors++;
      $display("FAIL add_out_value: cpu_out=%h, want 08", bus.cpu_out);
    end
  endtask

  task automatic test_jz_halt();
    hold_reset();
    clear_rom();
    rom[0] = ins(OP_LDI, 1, 0, 8'h80);
    rom[1] = ins(OP_SHL, 1, 0, 0);
    rom[2] = ins(OP_JZ,  0, 0, 6);
    rom[3] = ins(OP_OUT, 1, 0, 0);
    rom[6] = ins(OP_HLT, 0, 0, 0);
    release_reset();
    run_instrs(9, "jz_halt");
    checks++;
    if (dbg_z !== 1'b1 || bus.halted !== 1'b1 || bus.imem_addr !== 8'h06 || bus.cpu_out !== 8'h00) begin
      errors++;
      $display("FAIL jz_halt_final: z=%b halted=%b addr=%h out=%h, want 1 1 06 00",
               dbg_z, bus.halted, bus.imem_addr, bus.cpu_out);
    end
  endtask

  task automatic test_wrap();
    hold_reset();
    clear_rom();
    rom[0] = ins(OP_LDI, 1, 0, 8'hFF);
    rom[1] = ins(OP_LDI, 2, 0, 1);
    rom[2] = ins(OP_ADD, 1, 2, 0);
    rom[3] = ins(OP_OUT, 1, 0, 0);
    rom[4] = ins(OP_LDI, 3, 0, 0);
    rom[5] = ins(OP_SUB, 3, 2, 0);
    rom[6] = ins(OP_OUT, 3, 0, 0);
    rom[7] = ins(OP_HLT, 0, 0, 0);
    release_reset();
    run_instrs(8, "wrap");
    checks++;
    if (bus.cpu_out !== 8'hFF || dbg_z !== 1'b0) begin
      errors++;
      $display("FAIL wrap_final: cpu_out=%h z=%b, want FF 0", bus.cpu_out, dbg_z);
    end
  endtask

  task automatic test_pc_wrap();
    hold_reset();
    clear_rom();
    rom[0]   = ins(OP_JMP, 0, 0, 8'hFF);
    rom[255] = ins(OP_NOP, 0, 0, 0);
    release_reset();
    run_instrs(4, "pc_wrap");
    checks++;
    if (bus.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap_addr: imem_addr=%h, want 00", bus.imem_addr);
    end
  endtask

  task automatic test_illegal();
    hold_reset();
    clear_rom();
    rom[0] = ins(4'hE, 2, 3, 8'h5A);
    rom[1] = ins(OP_OUT, 0, 0, 0);
    rom[2] = ins(OP_NOP, 0, 0, 0);
    rom[3] = ins(4'hF, 1, 1, 8'h11);
    rom[4] = ins(OP_LDI, 1, 0, 7);
    release_reset();
    run_instrs(5, "illegal");
    checks++;
    if (bus.illegal !== 1'b1 || bus.cpu_out !== 8'h00 || bus.imem_addr !== 8'h05) begin
      errors++;
      $display("FAIL illegal_sticky: illegal=%b out=%h addr=%h, want 1 00 05",
               bus.illegal, bus.cpu_out, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      hold_reset();
      for (int i = 0; i < 256; i++) begin
        rom[i] = IW'($urandom);
        // Keep halts rare so most of the run exercises the datapath.
        if (rom[i][17:14] == OP_HLT && $urandom_range(0, 3) != 0) rom[i][17:14] = OP_OUT;
      end
      release_reset();
      run_instrs(40, "random");
    end
  endtask

  task automatic test_reset_mid();
    // Default core: reset during EXECUTE of ADD.
    hold_reset();
    clear_rom();
    rom[0] = ins(OP_LDI, 1, 0, 5);
    rom[1] = ins(OP_LDI, 2, 0, 3);
    rom[2] = ins(OP_ADD, 1, 2, 0);
    rom[3] = ins(OP_OUT, 1, 0, 0);
    release_reset();
    run_instrs(2, "reset_mid_pre");
    repeat (2) @(negedge clk);
    checks++;
    if (dbg_state !== ST_EXECUTE) begin
      errors++;
      $display("FAIL reset_mid_state: state=%0d, want %0d", dbg_state, ST_EXECUTE);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.imem_addr !== 8'h00 || bus.cpu_out !== 8'h00 || bus.out_valid !== 1'b0 ||
        bus.halted !== 1'b0 || bus.illegal !== 1'b0 || dbg_state !== ST_FETCH) begin
      errors++;
      $display("FAIL reset_mid_async: addr=%h out=%h ov=%b halted=%b illegal=%b state=%0d, want zeros",
               bus.imem_addr, bus.cpu_out, bus.out_valid, bus.halted, bus.illegal, dbg_state);
    end
    clear_rom();
    rom[0] = ins(OP_OUT, 1, 0, 0);
    rom[1] = ins(OP_OUT, 2, 0, 0);
    release_reset();
    run_instrs(2, "reset_mid_post");

    // Wide core: same scenario with 16-bit data and 16 registers.
    for (int i = 0; i < 256; i++) rom2[i] = '0;
    rom2[0] = ins2(OP_LDI, 9, 0, 8'hAB);
    rom2[1] = ins2(OP_OUT, 9, 0, 0);
    rom2[2] = ins2(OP_LDI, 10, 0, 8'h60);
    rom2[3] = ins2(OP_ADD, 9, 10, 0);
    rom2[4] = ins2(OP_OUT, 9, 0, 0);
    @(negedge clk);
    reset2 = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (out_valid2 !== 1'b1 || cpu_out2 !== 16'h00AB) begin
      errors++;
      $display("FAIL wide_out: out_valid=%b cpu_out=%h, want 1 00AB", out_valid2, cpu_out2);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (dbg_state2 !== ST_EXECUTE || imem_addr2 !== 8'h03) begin
      errors++;
      $display("FAIL wide_pre_state: state=%0d addr=%h, want %0d 03", dbg_state2, imem_addr2, ST_EXECUTE);
    end
    #2 reset2 = 1'b1;
    #1;
    checks++;
    if (imem_addr2 !== 8'h00 || cpu_out2 !== 16'h0000 || out_valid2 !== 1'b0 ||
        halted2 !== 1'b0 || illegal2 !== 1'b0 || dbg_z2 !== 1'b0 || dbg_state2 !== ST_FETCH) begin
      errors++;
      $display("FAIL wide_reset_async: addr=%h out=%h ov=%b halted=%b illegal=%b z=%b state=%0d, want zeros",
               imem_addr2, cpu_out2, out_valid2, halted2, illegal2, dbg_z2, dbg_state2);
    end
    rom2[0] = ins2(OP_OUT, 9, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset2 = 1'b0;
    checks++;
    if (imem_addr2 !== 8'h00) begin
      errors++;
      $display("FAIL wide_restart_addr: imem_addr=%h, want 00", imem_addr2);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid2 !== 1'b1 || cpu_out2 !== 16'h0000) begin
      errors++;
      $display("FAIL wide_reg_cleared: out_valid=%b cpu_out=%h, want 1 0000", out_valid2, cpu_out2);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_rom();
    for (int i = 0; i < 256; i++) rom2[i] = '0;
    test_reset();
    test_add_out();
    test_jz_halt();
    test_wrap();
    test_pc_wrap();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mini_cpu_core.md
MINI_CPU_CORE -- requirements
Module: mini_cpu_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register/ALU data width.
REQ-002 The block SHALL have parameter NREG, default 8, meaning register count (power of 2, >=2); RA_W = clog2(NREG).
REQ-003 The block SHALL have parameter PC_W, default 8, meaning PC and immediate width; INSTR_W = 4+2*RA_W+PC_W (default 18).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imem_addr  output  PC_W  instruction fetch address.
REQ-007 imem_data  input  INSTR_W  instruction word, valid one cycle after imem_addr is presented (synchronous ROM).
REQ-008 cpu_out  output  DATA_W  last value written by OUT, held between OUTs.
REQ-009 out_valid  output  1  one-cycle pulse when cpu_out is updated.
REQ-010 halted  output  1  high while in HALT.
REQ-011 illegal  output  1  sticky flag, set by a reserved opcode.

Function
REQ-012 Instruction fields SHALL be opcode[INSTR_W-1 -: 4], rd next RA_W bits, rs next RA_W bits, imm low PC_W bits.
REQ-013 The FSM SHALL have states FETCH, DECODE, EXECUTE, WRITEBACK, HALT; each non-halt instruction takes exactly 4 cycles.
REQ-014 FETCH: imem_addr=PC; DECODE: latch imem_data, read rd/rs; EXECUTE: compute result/branch; WRITEBACK: write rd, update PC, go to FETCH.
REQ-015 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (rd=rd op rs); 6 MOV rd=rs; 7 LDI rd=imm zero-extended or truncated to DATA_W.
REQ-016 Opcodes: 8 SHL rd=rd<<1, 9 SHR rd=rd>>1 (logical); A JMP PC=imm; B JZ PC=imm if Z else PC+1; C OUT cpu_out=rd; D HLT; E, F reserved.
REQ-017 ADD/SUB SHALL wrap modulo 2^DATA_W; no carry flag.
REQ-018 Z flag SHALL be updated by opcodes 1-5, 8, 9 only (Z = result==0) in WRITEBACK; all other opcodes preserve Z.
REQ-019 PC SHALL increment modulo 2^PC_W (PC 2^PC_W-1 wraps to 0) for all non-branch, non-halt instructions.
REQ-020 rd==rs SHALL use the pre-write value of the register as both operands.
REQ-021 out_valid SHALL pulse in the WRITEBACK cycle of OUT; cpu_out updates on that same edge.
REQ-022 HLT SHALL enter HALT with PC unchanged; HALT is left only by reset; halted=1 in HALT.
REQ-023 Reserved opcodes SHALL set illegal and otherwise execute as NOP.

Reset
REQ-024 On reset assertion, asynchronously: state=FETCH, PC=0, all registers=0, Z=0, cpu_out=0, out_valid=0, halted=0, illegal=0.
REQ-025 Reset mid-instruction SHALL abandon the instruction without register, PC or output writes; the first fetch after release is address 0.

Structure
REQ-026 A shared package cpu_pkg SHALL hold the opcode constants, the FSM state encoding and the field-width functions.
REQ-027 One combinational sub-module cpu_alu (parameter DATA_W; inputs opcode, a, b; outputs result, zero) SHALL implement opcodes 1-9.
REQ-028 Register file and FSM SHALL live in mini_cpu_core; no latches; all flops on posedge clk / posedge reset.

Verification
REQ-029 LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1 -> cpu_out=8, out_valid one pulse at cycle 16, imem_addr visits 0..3.
REQ-030 LDI r1,0x80; SHL r1; JZ 6; OUT r1; HLT at 6 -> Z=1, PC jumps to 6, no out_valid, halted=1 and stays high for 20 cycles.
REQ-031 LDI r1,0xFF; LDI r2,1; ADD r1,r2; OUT r1 -> cpu_out=0 (wrap); SUB on 0-1 -> 0xFF.
REQ-032 JMP 0xFF; ROM[0xFF]=NOP -> next fetch at address 0 (PC wrap).
REQ-033 Opcode 0xE then OUT r0 -> illegal=1 sticky, cpu_out=0, execution continues.
REQ-034 Assert reset during EXECUTE of ADD -> all outputs 0 immediately, destination register unchanged (0), restart fetch at 0; repeat with DATA_W=16, NREG=16.
